// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } if_state_e;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // Force a target address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_rsp_buf.sv
// Single-entry buffer that parks a fetched word while decode is stalled.
module if_rsp_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_data,
  output logic [31:0] data,
  output logic        valid
);

  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  // Clear wins over load so a redirect always empties the entry.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = 32'h0;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end
  end

  // Buffer storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding memory request, stall buffering and
// redirect/trap handling with a single dropped stale response.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic [31:0] pc_out,
  output logic [31:0] Instr_out,
  output logic        IF_ID_RegWrite,
  output logic        Instr_flush
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        drop_q, drop_d;

  logic        buf_load, buf_clear, buf_valid;
  logic [31:0] buf_data;

  logic        redir;
  logic [31:0] redir_tgt;

  // Trap target takes priority over a branch target in the same cycle.
  assign redir     = trap_valid | redirect_valid;
  assign redir_tgt = align_word(trap_valid ? trap_pc : redirect_pc);

  assign im_req_addr = req_addr_q;

  if_rsp_buf u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_data (im_rsp_data),
    .data      (buf_data),
    .valid     (buf_valid)
  );

  // Next-state, next-pc and IF/ID write controls.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_addr_d     = req_addr_q;
    drop_d         = drop_q;
    buf_load       = 1'b0;
    buf_clear      = 1'b0;
    im_req_valid   = 1'b0;
    IF_ID_RegWrite = 1'b0;
    Instr_flush    = 1'b0;
    Instr_out      = 32'h0;
    pc_out         = 32'h0;

    case (state_q)
      ST_IDLE: begin
        if (redir) pc_d = redir_tgt;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        im_req_valid = 1'b1;
        // A redirect here lets the pending request complete and drops its data.
        if (redir) begin
          pc_d   = redir_tgt;
          drop_d = 1'b1;
        end
        if (im_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (im_rsp_valid) begin
          state_d = ST_REQ;
          drop_d  = 1'b0;
          if (redir) begin
            pc_d = redir_tgt;
          end else if (!drop_q) begin
            if (stall_id) begin
              buf_load = 1'b1;
              state_d  = ST_HOLD;
            end else begin
              IF_ID_RegWrite = 1'b1;
              Instr_out      = im_rsp_data;
              pc_out         = req_addr_q;
              pc_d           = req_addr_q + 32'd4;
            end
          end
        end else if (redir) begin
          pc_d   = redir_tgt;
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redir) begin
          pc_d      = redir_tgt;
          buf_clear = 1'b1;
          state_d   = ST_REQ;
        end else if (!stall_id && buf_valid) begin
          IF_ID_RegWrite = 1'b1;
          Instr_out      = buf_data;
          pc_out         = req_addr_q;
          pc_d           = req_addr_q + 32'd4;
          buf_clear      = 1'b1;
          state_d        = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any redirect outside IDLE writes a bubble into IF/ID.
    if (redir && (state_q != ST_IDLE)) begin
      IF_ID_RegWrite = 1'b1;
      Instr_flush    = 1'b1;
    end

    // Every entry to REQ issues the most recent pc.
    if ((state_d == ST_REQ) && (state_q != ST_REQ)) req_addr_d = pc_d;
  end

  // State and address registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a 2-cycle-latency memory responder.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [31:0] im_req_addr;
  logic        im_rsp_valid;
  logic [31:0] im_rsp_data;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] pc_out;
  logic [31:0] Instr_out;
  logic        IF_ID_RegWrite;
  logic        Instr_flush;

  int n_cmp;
  int n_bad;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .im_req_valid   (im_req_valid),
    .im_req_ready   (im_req_ready),
    .im_req_addr    (im_req_addr),
    .im_rsp_valid   (im_rsp_valid),
    .im_rsp_data    (im_rsp_data),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .pc_out         (pc_out),
    .Instr_out      (Instr_out),
    .IF_ID_RegWrite (IF_ID_RegWrite),
    .Instr_flush    (Instr_flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory: answers each accepted request two cycles later with addr + 0x1000_0000.
  initial begin
    logic [31:0] a;
    im_rsp_valid = 1'b0;
    im_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst && im_req_valid && im_req_ready) begin
        a = im_req_addr;
        @(posedge clk);
        @(posedge clk);
        #1;
        im_rsp_valid = 1'b1;
        im_rsp_data  = a + 32'h1000_0000;
        @(posedge clk);
        #1;
        im_rsp_valid = 1'b0;
        im_rsp_data  = 32'h0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (im_req_valid !== 1'b1 && n < 20);
    check_eq({tag, "_valid"}, 32'(im_req_valid), 32'd1);
    check_eq({tag, "_addr"}, im_req_addr, exp_addr);
  endtask

  task automatic wait_deliver(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (IF_ID_RegWrite !== 1'b1 && n < 20);
    check_eq({tag, "_we"}, 32'(IF_ID_RegWrite), 32'd1);
    check_eq({tag, "_flush"}, 32'(Instr_flush), 32'd0);
    check_eq({tag, "_pc"}, pc_out, exp_pc);
    check_eq({tag, "_instr"}, Instr_out, exp_instr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(im_req_valid), 32'd0);
    check_eq({tag, "_we"}, 32'(IF_ID_RegWrite), 32'd0);
    check_eq({tag, "_flush"}, 32'(Instr_flush), 32'd0);
    check_eq({tag, "_pc_out"}, pc_out, 32'h0);
    check_eq({tag, "_instr"}, Instr_out, 32'h0);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b0;
    im_req_ready   = 1'b1;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    trap_valid     = 1'b0;
    trap_pc        = 32'h0;

    // Reset state.
    #2;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("idle_req_valid", 32'(im_req_valid), 32'd0);
    wait_req("first_req", 32'h0000_0000);

    // Sequential fetch of 0, 4, 8.
    wait_deliver("seq0", 32'h0000_0000, 32'h1000_0000);
    @(negedge clk);
    check_eq("seq0_pulse", 32'(IF_ID_RegWrite), 32'd0);
    check_eq("seq0_next", im_req_addr, 32'h0000_0004);
    wait_deliver("seq1", 32'h0000_0004, 32'h1000_0004);
    @(negedge clk);
    check_eq("seq1_pulse", 32'(IF_ID_RegWrite), 32'd0);
    check_eq("seq1_next", im_req_addr, 32'h0000_0008);
    wait_deliver("seq2", 32'h0000_0008, 32'h1000_0008);
    @(negedge clk);
    check_eq("seq2_pulse", 32'(IF_ID_RegWrite), 32'd0);
    check_eq("seq2_next", im_req_addr, 32'h0000_000C);

    // Stall for 3 cycles while the response for 0xC arrives.
    tick();
    stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_no_we", 32'(IF_ID_RegWrite), 32'd0);
    end
    tick();
    stall_id = 1'b0;
    @(negedge clk);
    check_eq("hold_we", 32'(IF_ID_RegWrite), 32'd1);
    check_eq("hold_pc", pc_out, 32'h0000_000C);
    check_eq("hold_instr", Instr_out, 32'h1000_000C);
    check_eq("hold_flush", 32'(Instr_flush), 32'd0);
    tick();
    @(negedge clk);
    check_eq("hold_once", 32'(IF_ID_RegWrite), 32'd0);
    check_eq("hold_next", im_req_addr, 32'h0000_0010);

    // Redirect to 0x102 while waiting on the 0x10 response.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(negedge clk);
    check_eq("wait_redir_flush", 32'(Instr_flush), 32'd1);
    check_eq("wait_redir_we", 32'(IF_ID_RegWrite), 32'd1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("wait_drop_we", 32'(IF_ID_RegWrite), 32'd0);
    wait_req("redir_req", 32'h0000_0100);
    wait_deliver("redir", 32'h0000_0100, 32'h1000_0100);

    // Trap and redirect together in REQ: trap wins.
    tick();
    trap_valid     = 1'b1;
    trap_pc        = 32'h8000_0000;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    @(negedge clk);
    check_eq("trap_flush", 32'(Instr_flush), 32'd1);
    check_eq("trap_req_kept", im_req_addr, 32'h0000_0104);
    tick();
    trap_valid     = 1'b0;
    redirect_valid = 1'b0;
    wait_req("trap_req", 32'h8000_0000);
    wait_deliver("trap", 32'h8000_0000, 32'h9000_0000);

    // Back-pressure for 4 cycles with a redirect in the middle.
    tick();
    im_req_ready = 1'b0;
    @(negedge clk);
    check_eq("bp_addr0", im_req_addr, 32'h8000_0004);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    check_eq("bp_flush", 32'(Instr_flush), 32'd1);
    check_eq("bp_addr1", im_req_addr, 32'h8000_0004);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_addr2", im_req_addr, 32'h8000_0004);
    tick();
    @(negedge clk);
    check_eq("bp_addr3", im_req_addr, 32'h8000_0004);
    tick();
    im_req_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_valid", 32'(im_req_valid), 32'd1);
    check_eq("bp_addr4", im_req_addr, 32'h8000_0004);
    tick();
    wait_req("bp_req", 32'h0000_0200);
    wait_deliver("bp", 32'h0000_0200, 32'h1000_0200);

    // Unaligned target at the top of memory, then wrap to 0.
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("top_flush", 32'(Instr_flush), 32'd1);
    tick();
    redirect_valid = 1'b0;
    wait_req("top_req", 32'hFFFF_FFFC);
    wait_deliver("top", 32'hFFFF_FFFC, 32'h0FFF_FFFC);
    tick();
    @(negedge clk);
    check_eq("wrap_addr", im_req_addr, 32'h0000_0000);

    // Reset in WAIT; late response lands in IDLE and is ignored.
    tick();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check_eq("late_rsp_we", 32'(IF_ID_RegWrite), 32'd0);
    check_eq("late_rsp_req", 32'(im_req_valid), 32'd0);
    @(negedge clk);
    check_eq("restart_valid", 32'(im_req_valid), 32'd1);
    check_eq("restart_addr", im_req_addr, 32'h0000_0000);
    wait_deliver("restart", 32'h0000_0000, 32'h1000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
